// File: rtl/dcache_arb_pkg.sv
// Shared definitions for the D-cache port arbiter.
//   state_e  : arbiter FSM encoding
//   size_e   : access size encoding carried on ld_size/st_size/c_size
//   *_DEF    : default parameter values for the arbiter and its interface
package dcache_arb_pkg;

  localparam int STARVE_MAX_DEF = 3;
  localparam int AW_DEF         = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LD_BUSY = 2'b01,
    ST_BUSY = 2'b10
  } state_e;

  // 2'b11 is reserved
  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_W16   = 2'b01,
    SZ_DWORD = 2'b10
  } size_e;

endpackage

// File: rtl/dcache_port_arb_if.sv
// Bundle of the load port, store-drain port and D-cache port of the arbiter.
//   master : requesters and cache (drive requests/ack, observe grants/done)
//   slave  : the arbiter itself
interface dcache_port_arb_if #(
  parameter int AW = dcache_arb_pkg::AW_DEF
);
  // load port
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [1:0]    ld_size;
  logic          ld_kill;
  logic          ld_gnt;
  logic          ld_done;
  logic [31:0]   ld_rdata;
  // store-drain port
  logic          st_req;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [1:0]    st_size;
  logic          st_urgent;
  logic          st_gnt;
  logic          st_done;
  // D-cache port
  logic          c_req;
  logic          c_wr;
  logic [AW-1:0] c_addr;
  logic [31:0]   c_wdata;
  logic [1:0]    c_size;
  logic          c_ack;
  logic [31:0]   c_rdata;

  modport master (
    output ld_req, ld_addr, ld_size, ld_kill,
    output st_req, st_addr, st_data, st_size, st_urgent,
    output c_ack, c_rdata,
    input  ld_gnt, ld_done, ld_rdata, st_gnt, st_done,
    input  c_req, c_wr, c_addr, c_wdata, c_size
  );

  modport slave (
    input  ld_req, ld_addr, ld_size, ld_kill,
    input  st_req, st_addr, st_data, st_size, st_urgent,
    input  c_ack, c_rdata,
    output ld_gnt, ld_done, ld_rdata, st_gnt, st_done,
    output c_req, c_wr, c_addr, c_wdata, c_size
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive load wins taken while a store was waiting.
//   clk, rst : clock, synchronous active-high reset
//   inc      : a load won while st_req was high
//   clr      : a store won
//   sat      : count has reached MAX; the waiting store must win next
module arb_starve_ctr #(
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == CW'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)             cnt_d = '0;
    else if (inc && !sat) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dcache_port_arb.sv
// Arbitrates one D-cache port between the memory-stage load and the
// write-buffer store drain. One transaction in flight at a time; requests
// seen while busy are dropped (requesters hold them until granted).
//   clk, rst : clock, synchronous active-high reset
//   bus      : load / store / cache port bundle (slave side)
//   busy     : FSM is not IDLE (decoded from the state register)
// All other outputs are registered.
module dcache_port_arb
  import dcache_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int AW         = AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  dcache_port_arb_if.slave    bus,
  output logic                busy
);

  state_e        state_q, state_d;
  logic          ld_gnt_q, ld_gnt_d;
  logic          st_gnt_q, st_gnt_d;
  logic          ld_done_q, ld_done_d;
  logic          st_done_q, st_done_d;
  logic [31:0]   ld_rdata_q, ld_rdata_d;
  logic          c_req_q, c_req_d;
  logic          c_wr_q, c_wr_d;
  logic [AW-1:0] c_addr_q, c_addr_d;
  logic [31:0]   c_wdata_q, c_wdata_d;
  logic [1:0]    c_size_q, c_size_d;
  logic          kill_q, kill_d;

  logic idle, ld_req_eff, st_win, ld_win, starve_sat;

  // Arbitration is only meaningful in IDLE; a killed load never competes.
  assign idle       = (state_q == IDLE);
  assign ld_req_eff = bus.ld_req && !bus.ld_kill;
  assign st_win     = idle && bus.st_req &&
                      (bus.st_urgent || starve_sat || !ld_req_eff);
  assign ld_win     = idle && !st_win && ld_req_eff;

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (ld_win && bus.st_req),
    .clr (st_win),
    .sat (starve_sat)
  );

  always_comb begin
    state_d    = state_q;
    ld_gnt_d   = 1'b0;
    st_gnt_d   = 1'b0;
    ld_done_d  = 1'b0;
    st_done_d  = 1'b0;
    ld_rdata_d = ld_rdata_q;
    c_req_d    = c_req_q;
    c_wr_d     = c_wr_q;
    c_addr_d   = c_addr_q;
    c_wdata_d  = c_wdata_q;
    c_size_d   = c_size_q;
    kill_d     = kill_q;
    case (state_q)
      IDLE: begin
        // c_ack here is spurious and deliberately ignored
        if (st_win) begin
          state_d   = ST_BUSY;
          st_gnt_d  = 1'b1;
          c_req_d   = 1'b1;
          c_wr_d    = 1'b1;
          c_addr_d  = bus.st_addr;
          c_wdata_d = bus.st_data;
          c_size_d  = bus.st_size;
        end else if (ld_win) begin
          state_d   = LD_BUSY;
          ld_gnt_d  = 1'b1;
          c_req_d   = 1'b1;
          c_wr_d    = 1'b0;
          c_addr_d  = bus.ld_addr;
          c_wdata_d = '0;
          c_size_d  = bus.ld_size;
        end
      end
      LD_BUSY: begin
        // A kill in the ack cycle itself still suppresses the done pulse,
        // so fold the live input in before deciding.
        kill_d = kill_q || bus.ld_kill;
        if (bus.c_ack) begin
          state_d = IDLE;
          c_req_d = 1'b0;
          if (!kill_d) begin
            ld_done_d  = 1'b1;
            ld_rdata_d = bus.c_rdata;
          end
          kill_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (bus.c_ack) begin
          state_d   = IDLE;
          c_req_d   = 1'b0;
          st_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        c_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ld_gnt_q   <= 1'b0;
      st_gnt_q   <= 1'b0;
      ld_done_q  <= 1'b0;
      st_done_q  <= 1'b0;
      ld_rdata_q <= '0;
      c_req_q    <= 1'b0;
      c_wr_q     <= 1'b0;
      c_addr_q   <= '0;
      c_wdata_q  <= '0;
      c_size_q   <= '0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_gnt_q   <= ld_gnt_d;
      st_gnt_q   <= st_gnt_d;
      ld_done_q  <= ld_done_d;
      st_done_q  <= st_done_d;
      ld_rdata_q <= ld_rdata_d;
      c_req_q    <= c_req_d;
      c_wr_q     <= c_wr_d;
      c_addr_q   <= c_addr_d;
      c_wdata_q  <= c_wdata_d;
      c_size_q   <= c_size_d;
      kill_q     <= kill_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign bus.ld_gnt   = ld_gnt_q;
  assign bus.st_gnt   = st_gnt_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.st_done  = st_done_q;
  assign bus.ld_rdata = ld_rdata_q;
  assign bus.c_req    = c_req_q;
  assign bus.c_wr     = c_wr_q;
  assign bus.c_addr   = c_addr_q;
  assign bus.c_wdata  = c_wdata_q;
  assign bus.c_size   = c_size_q;

endmodule

// File: tb/tb_dcache_port_arb.sv
// Self-checking bench for dcache_port_arb: directed scenarios followed by a
// randomized run, all checked every cycle against a transaction-level model.
module tb_dcache_port_arb;
  import dcache_arb_pkg::*;

  localparam int AW   = 15;
  localparam int SMAX = 3;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  dcache_port_arb_if #(.AW(AW)) bus ();

  dcache_port_arb #(.STARVE_MAX(SMAX), .AW(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  // m_kind: 0 = no transaction, 1 = load on the cache port, 2 = store
  int          m_kind   = 0;
  int          m_starve = 0;
  bit          m_killed = 0;
  logic        e_ld_gnt, e_st_gnt, e_ld_done, e_st_done, e_c_req, e_c_wr, e_busy;
  logic [AW-1:0] e_c_addr;
  logic [31:0] e_c_wdata, e_ld_rdata;
  logic [1:0]  e_c_size;

  // Predict the outputs visible after the coming clock edge from the
  // inputs currently driven.
  task automatic model_eval();
    bit ldv;
    if (rst) begin
      m_kind = 0; m_starve = 0; m_killed = 0;
      e_ld_gnt = 0; e_st_gnt = 0; e_ld_done = 0; e_st_done = 0;
      e_c_req = 0; e_c_wr = 0; e_c_addr = '0; e_c_wdata = '0; e_c_size = '0;
      e_ld_rdata = '0; e_busy = 0;
      return;
    end
    e_ld_gnt = 0; e_st_gnt = 0; e_ld_done = 0; e_st_done = 0;
    if (m_kind == 0) begin
      ldv = bus.ld_req && !bus.ld_kill;
      if (bus.st_req && (bus.st_urgent || m_starve == SMAX || !ldv)) begin
        m_kind = 2; e_st_gnt = 1; m_starve = 0;
        e_c_req = 1; e_c_wr = 1; e_c_addr = bus.st_addr;
        e_c_wdata = bus.st_data; e_c_size = bus.st_size;
      end else if (ldv) begin
        m_kind = 1; e_ld_gnt = 1;
        if (bus.st_req && m_starve < SMAX) m_starve++;
        e_c_req = 1; e_c_wr = 0; e_c_addr = bus.ld_addr;
        e_c_wdata = '0; e_c_size = bus.ld_size;
      end
    end else begin
      if (m_kind == 1 && bus.ld_kill) m_killed = 1;
      if (bus.c_ack) begin
        if (m_kind == 1 && !m_killed) begin
          e_ld_done = 1; e_ld_rdata = bus.c_rdata;
        end
        if (m_kind == 2) e_st_done = 1;
        m_kind = 0; m_killed = 0; e_c_req = 0;
      end
    end
    e_busy = (m_kind != 0);
  endtask

  task automatic check_all();
    chk("ld_gnt",   bus.ld_gnt,   e_ld_gnt);
    chk("st_gnt",   bus.st_gnt,   e_st_gnt);
    chk("ld_done",  bus.ld_done,  e_ld_done);
    chk("st_done",  bus.st_done,  e_st_done);
    chk("ld_rdata", bus.ld_rdata, e_ld_rdata);
    chk("c_req",    bus.c_req,    e_c_req);
    chk("busy",     busy,         e_busy);
    chk("starve",   dut.u_starve.cnt_q, m_starve);
    if (e_c_req) begin
      chk("c_wr",    bus.c_wr,    e_c_wr);
      chk("c_addr",  bus.c_addr,  e_c_addr);
      chk("c_wdata", bus.c_wdata, e_c_wdata);
      chk("c_size",  bus.c_size,  e_c_size);
    end
  endtask

  // one clock: predict, let the edge pass, compare 1 ns later
  task automatic cyc();
    model_eval();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clr_in();
    bus.ld_req = 0; bus.ld_addr = '0; bus.ld_size = '0; bus.ld_kill = 0;
    bus.st_req = 0; bus.st_addr = '0; bus.st_data = '0; bus.st_size = '0;
    bus.st_urgent = 0; bus.c_ack = 0; bus.c_rdata = '0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1; cyc();
    if (bus.c_addr !== '0) chk("rst_c_addr", bus.c_addr, '0);
    chk("rst_c_wr", bus.c_wr, 0);
    rst = 0;
  endtask

  int  nld;
  bit  got;

  initial begin
    rst = 1;
    clr_in();

    // ---- reset state ----
    do_reset();

    // ---- lone load ----
    bus.ld_req = 1; bus.ld_addr = 15'h0123; bus.ld_size = SZ_W16;
    cyc();                                   // T+1
    chk("lone_gnt", bus.ld_gnt, 1);
    chk("lone_addr", bus.c_addr, 15'h0123);
    bus.ld_req = 0;
    cyc();                                   // T+2
    chk("lone_creq2", bus.c_req, 1);
    cyc();                                   // T+3
    chk("lone_creq3", bus.c_req, 1);
    bus.c_ack = 1; bus.c_rdata = 32'hDEADBEEF;
    cyc();                                   // T+4
    bus.c_ack = 0; bus.c_rdata = '0;
    chk("lone_done", bus.ld_done, 1);
    chk("lone_rdata", bus.ld_rdata, 32'hDEADBEEF);
    chk("lone_creq4", bus.c_req, 0);
    cyc();
    chk("lone_rdata_hold", bus.ld_rdata, 32'hDEADBEEF);

    // ---- collision: 3 loads then the store ----
    do_reset();
    bus.ld_req = 1; bus.ld_addr = 15'h0040;
    bus.st_req = 1; bus.st_addr = 15'h0200; bus.st_data = 32'h11112222;
    nld = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      bus.c_ack = e_c_req;
      cyc();
      if (e_st_gnt) got = 1;
      else if (e_ld_gnt) nld++;
    end
    bus.st_req = 0;
    chk("coll_st_seen", got, 1);
    chk("coll_nld", nld, 3);
    bus.c_ack = 0; bus.ld_req = 0;
    cyc();
    bus.c_ack = 1; cyc(); bus.c_ack = 0;

    // ---- urgent store beats load ----
    do_reset();
    bus.ld_req = 1; bus.st_req = 1; bus.st_urgent = 1;
    bus.st_addr = 15'h7ABC; bus.st_data = 32'hCAFEF00D; bus.st_size = SZ_DWORD;
    cyc();
    chk("urg_st_gnt", bus.st_gnt, 1);
    chk("urg_ld_gnt", bus.ld_gnt, 0);
    chk("urg_c_wr", bus.c_wr, 1);
    chk("urg_wdata", bus.c_wdata, 32'hCAFEF00D);
    bus.st_req = 0; bus.st_urgent = 0; bus.ld_req = 0;
    bus.c_ack = 1; cyc(); bus.c_ack = 0;
    chk("urg_st_done", bus.st_done, 1);

    // ---- kill mid-flight ----
    do_reset();
    bus.ld_req = 1; bus.ld_addr = 15'h0055;
    cyc();
    chk("kill_gnt", bus.ld_gnt, 1);
    bus.ld_req = 0;
    cyc();
    bus.ld_kill = 1; cyc(); bus.ld_kill = 0;
    cyc();
    chk("kill_busy", busy, 1);
    bus.c_ack = 1; bus.c_rdata = 32'h0BADF00D;
    bus.st_req = 1; bus.st_addr = 15'h0101; bus.st_data = 32'h5A5A5A5A;
    cyc();
    bus.c_ack = 0;
    chk("kill_no_done", bus.ld_done, 0);
    chk("kill_idle", busy, 0);
    chk("kill_rdata_kept", bus.ld_rdata, 0);
    cyc();
    chk("kill_st_gnt", bus.st_gnt, 1);
    bus.st_req = 0;
    bus.c_ack = 1; cyc(); bus.c_ack = 0;
    chk("kill_st_done", bus.st_done, 1);

    // ---- reset while in ST_BUSY ----
    do_reset();
    bus.st_req = 1; bus.st_addr = 15'h3333; bus.st_data = 32'h12345678;
    cyc();
    chk("rstb_st_gnt", bus.st_gnt, 1);
    bus.st_req = 0;
    cyc();
    rst = 1; bus.c_ack = 1; cyc(); rst = 0; bus.c_ack = 0;
    chk("rstb_c_req", bus.c_req, 0);
    chk("rstb_busy", busy, 0);
    chk("rstb_st_done", bus.st_done, 0);
    chk("rstb_c_addr", bus.c_addr, 0);
    chk("rstb_c_wdata", bus.c_wdata, 0);
    cyc();
    chk("rstb_st_done2", bus.st_done, 0);

    // ---- spurious ack in IDLE ----
    bus.c_ack = 1; bus.c_rdata = 32'hFFFF0000;
    cyc();
    bus.c_ack = 0;
    chk("spur_ld_done", bus.ld_done, 0);
    chk("spur_st_done", bus.st_done, 0);
    chk("spur_busy", busy, 0);

    // ---- randomized traffic ----
    for (int i = 0; i < 1500; i++) begin
      if (!bus.ld_req && ($urandom % 3 == 0)) begin
        bus.ld_req  = 1;
        bus.ld_addr = AW'($urandom);
        bus.ld_size = 2'($urandom % 3);
      end
      if (!bus.st_req && ($urandom % 3 == 0)) begin
        bus.st_req  = 1;
        bus.st_addr = AW'($urandom);
        bus.st_data = $urandom;
        bus.st_size = 2'($urandom % 3);
      end
      bus.st_urgent = ($urandom % 5 == 0);
      bus.ld_kill   = ($urandom % 12 == 0);
      bus.c_ack     = e_c_req ? ($urandom % 3 == 0) : ($urandom % 25 == 0);
      bus.c_rdata   = $urandom;
      rst           = ($urandom % 200 == 0);
      cyc();
      if (e_ld_gnt) bus.ld_req = 0;
      if (e_st_gnt) bus.st_req = 0;
      if (rst) begin bus.ld_req = 0; bus.st_req = 0; end
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dcache_port_arb.md
DCACHE_PORT_ARB -- requirements
Module: dcache_port_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, giving the consecutive load wins allowed while a store waits.
REQ-002 SHALL have parameter AW, default 15, giving the physical address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ld_req / ld_addr / ld_size  input  1/AW/2  load request from the memory stage; held until ld_gnt.
REQ-006 ld_kill  input  1  pipeline invalidate of the pending or in-flight load.
REQ-007 st_req / st_addr / st_data / st_size  input  1/AW/32/2  store drain request from the write buffer; held until st_gnt.
REQ-008 st_urgent  input  1  write buffer full; store takes priority.
REQ-009 ld_gnt, st_gnt  output  1 each  one-cycle grant pulses.
REQ-010 ld_done / ld_rdata  output  1/32  load completion pulse and its data.
REQ-011 st_done  output  1  store completion pulse.
REQ-012 c_req / c_wr / c_addr / c_wdata / c_size  output  1/1/AW/32/2  D-cache port request.
REQ-013 c_ack / c_rdata  input  1/32  D-cache completion, 1-cycle pulse; c_rdata is valid with c_ack.
REQ-014 busy  output  1  state is not IDLE.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, LD_BUSY, ST_BUSY.
REQ-016 In IDLE, the arbiter SHALL evaluate requests each cycle, with these conditions:
- a store wins if st_req && (st_urgent || starve_cnt==STARVE_MAX || !ld_req_eff);
- otherwise a load wins if ld_req_eff;
- ld_req_eff = ld_req && !ld_kill.
REQ-017 A win in cycle T SHALL cause the following in cycle T+1:
- the FSM is in LD_BUSY or ST_BUSY;
- the matching gnt is high for exactly one cycle;
- c_req=1, with c_addr/c_size/c_wdata/c_wr registered from the winner (c_wr=1 only for a store).
REQ-018 c_req and the c_* fields SHALL remain stable until the cycle c_ack=1.
REQ-019 On c_ack in cycle N, in cycle N+1:
- c_req=0 and the FSM returns to IDLE;
- ld_done=1 with ld_rdata=c_rdata captured at N, or st_done=1.
REQ-020 IDLE in N+1 MAY arbitrate again, so a back-to-back request reaches c_req at N+2 at the earliest (minimum 2-cycle gap).
REQ-021 Requests arriving while busy SHALL be ignored and not queued; requesters hold them.
REQ-022 starve_cnt SHALL be a saturating counter of width clog2(STARVE_MAX+1), updated as follows:
- +1 on a load grant while st_req=1;
- cleared on a store grant;
- held otherwise.
REQ-023 ld_kill during LD_BUSY, or in the c_ack cycle of a load, SHALL set a kill flag; ld_done SHALL then be suppressed, but the FSM still waits for c_ack before leaving LD_BUSY.
REQ-024 ld_kill SHALL NOT affect an in-flight store or st_done.
REQ-025 c_ack in IDLE (spurious) SHALL be ignored and produce no done pulse.
REQ-026 ld_rdata SHALL hold its last value when ld_done=0.
REQ-027 busy SHALL equal (state != IDLE), decoded from registered state.

Reset
REQ-028 On rst=1 at a clock edge:
- state=IDLE, starve_cnt=0, kill flag=0;
- ld_gnt, st_gnt, ld_done, st_done, c_req, c_wr=0;
- c_addr, c_wdata, c_size, ld_rdata=0.
REQ-029 Reset mid-transaction SHALL abandon it: no done pulse, and c_req=0 from the next cycle; the cache side is flushed by the same rst.
REQ-030 rst SHALL override all other inputs in the same cycle.

Structure
REQ-031 The state encoding, STARVE_MAX default, AW, and size encodings (00 byte, 01 word16, 10 dword) SHALL live in a shared package, dcache_arb_pkg.
REQ-032 The starvation counter SHALL be one sub-module, arb_starve_ctr (inc, clr, sat output).
REQ-033 All outputs SHALL be registered except busy, which is decoded from the state register.

Verification
REQ-034 Lone load: ld_req at T, addr 0x0123, with c_ack at T+3 and c_rdata=0xDEADBEEF -> ld_gnt@T+1, c_req T+1..T+3, ld_done@T+4 with ld_rdata=0xDEADBEEF.
REQ-035 Collision: ld_req and st_req both high from T, no urgent, c_ack 1 cycle after each c_req:
- 3 load grants, then st_gnt;
- starve_cnt 0->1->2->3->0.
REQ-036 Urgent: ld_req=st_req=st_urgent=1 at T -> st_gnt@T+1, c_wr=1, c_wdata=st_data.
REQ-037 Kill: load granted, ld_kill pulsed mid-flight, c_ack later -> no ld_done, FSM IDLE the cycle after c_ack, and the next st_req is served.
REQ-038 Reset: rst while in ST_BUSY -> next cycle c_req=0, busy=0, no st_done, and all outputs at reset values.
REQ-039 Spurious: c_ack pulsed in IDLE -> no ld_done or st_done, and the state is unchanged.
